mem_port_arbiter: RTL

- Shares one single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline.
- Serialises accesses and holds one outstanding transaction at a time.
- Generates stall requests (stall_f, stall_m) that the pipeline control ORs into its existing StallF/StallD/FlushE logic.
- Discards fetch responses killed by a taken branch (PCSrcE).

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port.
// Contents:
//   XLEN_DEF / AW_DEF - default word and byte-address widths
//   BE_W              - byte-enable width for the default word width
//   arb_state_t       - arbiter FSM states (3-bit encoding)
package riscv_mem_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 32;
  localparam int BE_W     = XLEN_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_F_REQ  = 3'd3,
    ST_F_WAIT = 3'd4,
    ST_F_DROP = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch stage
// (IF) and the memory stage (MEM). One transaction is outstanding at a time;
// data accesses win over fetches because MEM holds the older instruction.
// Fetch responses killed by a taken branch (flush_f) are silently dropped.
//
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   if_req/if_addr                   - fetch request (address held while stalled)
//   if_ready/if_rdata                - one-cycle pulse with registered instruction
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be - MEM-stage load/store request
//   dm_ready/dm_rdata                - one-cycle pulse, registered load data
//   flush_f                          - current fetch is wrong-path
//   stall_f/stall_m                  - combinational stall requests to pipeline
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_gnt - memory request channel
//   mem_rvalid/mem_rdata             - memory response / write acknowledge
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_ready,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  input  logic [XLEN/8-1:0] dm_be,
  output logic              dm_ready,
  output logic [XLEN-1:0]   dm_rdata,
  input  logic              flush_f,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN/8-1:0] mem_be_q, mem_be_d;
  logic              if_ready_q, if_ready_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic              dm_ready_q, dm_ready_d;
  logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;

  // A requester whose ready pulse is showing this cycle still has its req
  // high; it must not be mistaken for a new request.
  logic dm_go, if_go, hs;

  assign dm_go = dm_req & ~dm_ready_q;
  assign if_go = if_req & ~if_ready_q & ~flush_f;
  // gnt only counts once mem_req is actually visible to the memory.
  assign hs    = mem_req_q & mem_gnt;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_ready_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dm_go) begin
          state_d     = ST_D_REQ;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
        end else if (if_go) begin
          state_d     = ST_F_REQ;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end
      ST_D_REQ: begin
        mem_req_d = 1'b1;
        if (hs) begin
          mem_req_d = 1'b0;
          state_d   = ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (mem_rvalid) begin
          state_d    = ST_IDLE;
          dm_ready_d = 1'b1;
          // A store acknowledge carries no data; keep the last load value.
          if (!mem_we_q) dm_rdata_d = mem_rdata;
        end
      end
      ST_F_REQ: begin
        if (flush_f) begin
          // Once granted the response is owed to us and must be absorbed.
          mem_req_d = 1'b0;
          state_d   = hs ? ST_F_DROP : ST_IDLE;
        end else if (hs) begin
          mem_req_d = 1'b0;
          state_d   = ST_F_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_F_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (!flush_f) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (flush_f) begin
          state_d = ST_F_DROP;
        end
      end
      ST_F_DROP: begin
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_ready_q  <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_ready_q  <= dm_ready_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_f = if_req & ~if_ready_q;
  assign stall_m = dm_req & ~dm_ready_q;

endmodule
